hazard_stall_ctrl: RTL

//   Pipeline sequencing controller for the 5-stage RISCV core. Sits beside the forwarding

---
 rtl/hazard_stall_ctrl_pkg.sv | 36 +++
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_mc_counter.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core definitions: opcodes used by hazard/forwarding logic, the
// hazard FSM state type, and source-register usage decoders.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } hazard_state_e;

  // True when the instruction actually reads rs1 (not just has bits there).
  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
      OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR: uses_rs1 = 1'b1;
      default:                                  uses_rs1 = 1'b0;
    endcase
  endfunction

  // True when the instruction actually reads rs2; I-type immediates overlap
  // the rs2 field and must not create false hazards.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: uses_rs2 = 1'b1;
      default:                                uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-stage view seen by the hazard controller: decode/execute
// instruction fields in, stall/flush/bubble controls out.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic [6:0]    id_instr_opcode_ip;
  logic [4:0]    id_rs1_ip;
  logic [4:0]    id_rs2_ip;
  logic [6:0]    ex_instr_opcode_ip;
  logic [4:0]    ex_dest_ip;
  logic          ex_mc_start_ip;
  logic          ex_branch_taken_ip;

  logic          pc_stall_op;
  logic          if_id_stall_op;
  logic          if_id_flush_op;
  logic          id_ex_bubble_op;
  logic          ex_hold_op;
  logic          ex_mem_bubble_op;
  logic          mc_done_op;
  hazard_state_e state_op;
  logic [15:0]   stall_cnt_op;

  modport master (
    output id_instr_opcode_ip, id_rs1_ip, id_rs2_ip,
           ex_instr_opcode_ip, ex_dest_ip, ex_mc_start_ip, ex_branch_taken_ip,
    input  pc_stall_op, if_id_stall_op, if_id_flush_op, id_ex_bubble_op,
           ex_hold_op, ex_mem_bubble_op, mc_done_op, state_op, stall_cnt_op
  );

  modport slave (
    input  id_instr_opcode_ip, id_rs1_ip, id_rs2_ip,
           ex_instr_opcode_ip, ex_dest_ip, ex_mc_start_ip, ex_branch_taken_ip,
    output pc_stall_op, if_id_stall_op, if_id_flush_op, id_ex_bubble_op,
           ex_hold_op, ex_mem_bubble_op, mc_done_op, state_op, stall_cnt_op
  );
endinterface

// File: rtl/hazard_mc_counter.sv
// Down-counter tracking the remaining busy cycles of a multi-cycle EX op.
module hazard_mc_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  // Load has priority over decrement; reset clears so no stale count survives.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle EX holds and
// taken-branch flushes. Controls are combinational from state + inputs.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(MC_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

  hazard_state_e    state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt;
  logic             load_use, mc_stall, br_live, lu_live, done;
  logic             pc_stall;

  hazard_mc_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  // Load in EX writing a register the decoding instr really reads; x0 never hazards.
  assign load_use = (bus.ex_instr_opcode_ip == OPCODE_LOAD) && (bus.ex_dest_ip != 5'd0) &&
                    ((uses_rs1(bus.id_instr_opcode_ip) && (bus.id_rs1_ip == bus.ex_dest_ip)) ||
                     (uses_rs2(bus.id_instr_opcode_ip) && (bus.id_rs2_ip == bus.ex_dest_ip)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state and hazard classification; branch wins over MC start and load-use.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    mc_stall = 1'b0;
    br_live  = 1'b0;
    lu_live  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.ex_branch_taken_ip) begin
          br_live = 1'b1;
        end else if (bus.ex_mc_start_ip) begin
          mc_stall = 1'b1;
          cnt_load = 1'b1;
          state_d  = (MC_LATENCY == 2) ? MC_DONE : MC_BUSY;
        end else begin
          lu_live = load_use;
        end
      end
      MC_BUSY: begin
        // A taken branch cannot legally appear here, so it is not looked at.
        mc_stall = 1'b1;
        if (cnt_is_one) state_d = MC_DONE;
        else            cnt_dec = 1'b1;
      end
      MC_DONE: begin
        // Result lands in EX/MEM now; ex_mc_start_ip still high is the same op.
        done    = 1'b1;
        state_d = RUN;
        if (bus.ex_branch_taken_ip) br_live = 1'b1;
        else                        lu_live = load_use;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_stall             = !reset && (mc_stall || lu_live);
  assign bus.pc_stall_op      = pc_stall;
  assign bus.if_id_stall_op   = pc_stall;
  assign bus.if_id_flush_op   = !reset && br_live;
  assign bus.id_ex_bubble_op  = !reset && (br_live || lu_live);
  assign bus.ex_hold_op       = !reset && mc_stall;
  assign bus.ex_mem_bubble_op = !reset && mc_stall;
  assign bus.mc_done_op       = !reset && done;
  assign bus.state_op         = state_q;

  // Saturating count of PC-stall cycles for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset)                                   bus.stall_cnt_op <= 16'd0;
    else if (pc_stall && bus.stall_cnt_op != 16'hFFFF) bus.stall_cnt_op <= bus.stall_cnt_op + 16'd1;
  end

endmodule
